// File: rtl/des_key_schedule_if.sv
// Key-in / subkey-out handshake bundle between the DES key scheduler and its neighbours.
interface des_key_schedule_if;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key;
    logic        mode;
    logic        abort;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        last;
    logic        key_err;

    modport master (
        output key_valid, key, mode, abort, subkey_ready,
        input  key_ready, subkey_valid, subkey, round, last, key_err
    );

    modport slave (
        input  key_valid, key, mode, abort, subkey_ready,
        output key_ready, subkey_valid, subkey, round, last, key_err
    );
endinterface

// File: rtl/des_key_schedule.sv
// Iterative DES round-key generator: PC-1 on key load, one PC-2 subkey per handshake.
// Decrypt order comes from right-rotating C/D, so no subkey storage is kept.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for a key, key_ready=1
// ST_GEN  | presenting subkey for round counter q, subkey_valid=1
module des_key_schedule #(
    parameter int PARITY_CHECK = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    des_key_schedule_if.slave  bus
);

    typedef enum logic {ST_IDLE, ST_GEN} state_t;

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1_TBL[i]];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_TBL[i]];
        return o;
    endfunction

    // Rounds 1, 2, 9 and 16 rotate by one; all others by two.
    function automatic logic shift_is_two(input logic [4:0] rnd);
        return !(rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16);
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic right, input logic two);
        logic [27:0] o;
        case ({right, two})
            2'b00:   o = {x[26:0], x[27]};
            2'b01:   o = {x[25:0], x[27:26]};
            2'b10:   o = {x[0], x[27:1]};
            default: o = {x[1:0], x[27:2]};
        endcase
        return o;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_q;
    logic        r_mode;
    logic        r_key_err;

    logic        w_key_ready;
    logic        w_subkey_valid;
    logic        w_key_hs;
    logic        w_sub_hs;
    logic        w_parity_ok;
    logic [55:0] w_pc1;
    logic [4:0]  w_rnd_enc;
    logic [4:0]  w_rnd_dec;
    logic        w_two;
    logic [7:0]  w_byte_odd;

    always_comb begin
        for (int i = 0; i < 8; i++) w_byte_odd[i] = ^bus.key[8*i +: 8];
    end

    assign w_parity_ok = (PARITY_CHECK == 0) || (&w_byte_odd);
    assign w_key_hs    = w_key_ready && bus.key_valid && !bus.abort;
    assign w_sub_hs    = w_subkey_valid && bus.subkey_ready && !bus.abort;
    assign w_pc1       = pc1(bus.key);
    assign w_rnd_enc   = {1'b0, r_q} + 5'd2;
    assign w_rnd_dec   = 5'd16 - {1'b0, r_q};
    assign w_two       = r_mode ? shift_is_two(w_rnd_dec) : shift_is_two(w_rnd_enc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_key_ready    = 1'b0;
        w_subkey_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_key_ready = 1'b1;
                if (bus.key_valid && !bus.abort && w_parity_ok) w_state_nxt = ST_GEN;
            end
            ST_GEN: begin
                w_subkey_valid = 1'b1;
                if (bus.abort)                                 w_state_nxt = ST_IDLE;
                else if (bus.subkey_ready && r_q == 4'd15)     w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c       <= '0;
            r_d       <= '0;
            r_q       <= '0;
            r_mode    <= 1'b0;
            r_key_err <= 1'b0;
        end else begin
            r_key_err <= w_key_hs && !w_parity_ok;
            if (bus.abort) begin
                r_q <= '0;
            end else if (w_key_hs && w_parity_ok) begin
                r_mode <= bus.mode;
                r_q    <= '0;
                // Decrypt starts at C16/D16, which equals C0/D0 after 28 total rotations.
                if (bus.mode) begin
                    r_c <= w_pc1[55:28];
                    r_d <= w_pc1[27:0];
                end else begin
                    r_c <= rot28(w_pc1[55:28], 1'b0, 1'b0);
                    r_d <= rot28(w_pc1[27:0],  1'b0, 1'b0);
                end
            end else if (w_sub_hs) begin
                if (r_q == 4'd15) begin
                    r_q <= '0;
                end else begin
                    r_q <= r_q + 4'd1;
                    r_c <= rot28(r_c, r_mode, w_two);
                    r_d <= rot28(r_d, r_mode, w_two);
                end
            end
        end
    end

    assign bus.key_ready    = w_key_ready;
    assign bus.subkey_valid = w_subkey_valid;
    assign bus.subkey       = (r_state == ST_GEN) ? pc2({r_c, r_d}) : 48'd0;
    assign bus.round        = (r_state == ST_GEN) ? (r_mode ? 4'd15 - r_q : r_q) : 4'd0;
    assign bus.last         = (r_state == ST_GEN) && (r_q == 4'd15);
    assign bus.key_err      = r_key_err;

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized bench for des_key_schedule against a closed-form DES key-schedule model.
module tb_des_key_schedule;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    des_key_schedule_if bus0();
    des_key_schedule_if bus1();

    des_key_schedule #(.PARITY_CHECK(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    des_key_schedule #(.PARITY_CHECK(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic [47:0] got [16];
    logic [47:0] got_enc [16];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Subkey for DES round r (1..16), rotating C0/D0 by the cumulative shift in one step.
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int r);
        logic [27:0] c0, d0, c, d;
        logic [55:0] tc, td, cd;
        logic [47:0] o;
        int tot;
        for (int i = 0; i < 28; i++) begin
            c0[27-i] = k[64-PC1[i]];
            d0[27-i] = k[64-PC1[i+28]];
        end
        tot = 0;
        for (int j = 0; j < r; j++) tot += SHIFTS[j];
        tot = tot % 28;
        tc = {c0, c0} << tot;
        td = {d0, d0} << tot;
        c  = tc[55:28];
        d  = td[55:28];
        cd = {c, d};
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2[i]];
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // abort_at: index of the presented subkey on which abort is raised, -1 for none.
    task automatic run_job(input logic [63:0] k, input logic m, input int ready_pct, input int abort_at);
        int idx;
        int budget;
        logic rdy;
        int rnd;
        budget = 0;
        while (!bus0.key_ready && budget < 50) begin
            tick();
            budget++;
        end
        check_eq("key_ready_wait", bus0.key_ready, 1);
        bus0.key       = k;
        bus0.mode      = m;
        bus0.key_valid = 1'b1;
        tick();
        bus0.key_valid = 1'b0;
        bus0.key       = $urandom();
        check_eq("latency_valid", bus0.subkey_valid, 1);
        idx = 0;
        budget = 0;
        while (idx < 16 && budget < 600) begin
            budget++;
            if (!bus0.subkey_valid) begin
                check_eq("valid_mid_job", bus0.subkey_valid, 1);
                break;
            end
            rnd = m ? 16 - idx : idx + 1;
            check_eq("subkey", bus0.subkey, ref_subkey(k, rnd));
            check_eq("round", bus0.round, rnd - 1);
            check_eq("last", bus0.last, idx == 15);
            check_eq("key_ready_gen", bus0.key_ready, 0);
            got[idx] = bus0.subkey;
            if (idx == abort_at) begin
                bus0.subkey_ready = 1'b1;
                bus0.abort        = 1'b1;
                tick();
                bus0.abort        = 1'b0;
                bus0.subkey_ready = 1'b0;
                check_eq("abort_valid", bus0.subkey_valid, 0);
                check_eq("abort_ready", bus0.key_ready, 1);
                return;
            end
            rdy = ($urandom_range(99) < ready_pct);
            bus0.subkey_ready = rdy;
            tick();
            if (rdy) idx++;
        end
        bus0.subkey_ready = 1'b0;
        check_eq("job_count", idx, 16);
        check_eq("end_valid", bus0.subkey_valid, 0);
        check_eq("end_ready", bus0.key_ready, 1);
    endtask

    initial begin
        logic [63:0] k;
        int n;
        bus0.key_valid = 0; bus0.key = '0; bus0.mode = 0; bus0.abort = 0; bus0.subkey_ready = 0;
        bus1.key_valid = 0; bus1.key = '0; bus1.mode = 0; bus1.abort = 0; bus1.subkey_ready = 0;
        #1;
        check_eq("rst_key_ready", bus0.key_ready, 1);
        check_eq("rst_valid", bus0.subkey_valid, 0);
        check_eq("rst_subkey", bus0.subkey, 0);
        check_eq("rst_round", bus0.round, 0);
        check_eq("rst_last", bus0.last, 0);
        check_eq("rst_key_err", bus0.key_err, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Known-answer encrypt and decrypt runs.
        run_job(64'h133457799BBCDFF1, 1'b0, 100, -1);
        for (int i = 0; i < 16; i++) got_enc[i] = got[i];
        check_eq("kat_k1", got_enc[0], 48'h1B02EFFC7072);
        check_eq("kat_k2", got_enc[1], 48'h79AED9DBC9E5);
        check_eq("kat_k16", got_enc[15], 48'hCB3D8B0E17F5);
        run_job(64'h133457799BBCDFF1, 1'b1, 100, -1);
        check_eq("kat_dec_first", got[0], 48'hCB3D8B0E17F5);
        for (int i = 0; i < 16; i++) check_eq("dec_reverse", got[i], got_enc[15-i]);

        // Backpressure on the known key, then random keys/modes with random stalls.
        run_job(64'h133457799BBCDFF1, 1'b0, 40, -1);
        for (int i = 0; i < 16; i++) check_eq("stall_same", got[i], got_enc[i]);
        for (int t = 0; t < 6; t++) begin
            k = {$urandom(), $urandom()};
            run_job(k, 1'($urandom_range(1)), 30 + 10 * t, -1);
        end

        // Abort on round 6, then an all-zero key.
        run_job({$urandom(), $urandom()}, 1'b0, 100, 5);
        check_eq("abort_hold", bus0.subkey_valid, 0);
        run_job(64'h0, 1'b0, 100, -1);
        for (int i = 0; i < 16; i++) check_eq("zero_key", got[i], 0);

        // Abort together with key_valid in IDLE drops the key.
        bus0.key = 64'h133457799BBCDFF1; bus0.key_valid = 1'b1; bus0.abort = 1'b1;
        tick();
        bus0.key_valid = 1'b0; bus0.abort = 1'b0;
        check_eq("abort_drop_valid", bus0.subkey_valid, 0);
        check_eq("abort_drop_ready", bus0.key_ready, 1);
        tick();
        check_eq("abort_drop_later", bus0.subkey_valid, 0);

        // Parity-checking instance.
        check_eq("nochk_key_err", bus0.key_err, 0);
        bus1.key = 64'h133457799BBCDFF0; bus1.key_valid = 1'b1;
        tick();
        bus1.key_valid = 1'b0;
        check_eq("par_err_pulse", bus1.key_err, 1);
        check_eq("par_err_valid", bus1.subkey_valid, 0);
        check_eq("par_err_ready", bus1.key_ready, 1);
        tick();
        check_eq("par_err_clear", bus1.key_err, 0);
        check_eq("par_err_valid2", bus1.subkey_valid, 0);
        bus1.key = 64'h133457799BBCDFF1; bus1.key_valid = 1'b1; bus1.subkey_ready = 1'b1;
        tick();
        bus1.key_valid = 1'b0;
        check_eq("par_ok_err", bus1.key_err, 0);
        check_eq("par_ok_valid", bus1.subkey_valid, 1);
        check_eq("par_ok_k1", bus1.subkey, 48'h1B02EFFC7072);
        n = 0;
        while (bus1.subkey_valid && n < 40) begin
            n++;
            tick();
        end
        check_eq("par_ok_count", n, 16);
        bus1.subkey_ready = 1'b0;

        // Asynchronous reset mid-job.
        bus0.key = 64'h133457799BBCDFF1; bus0.mode = 1'b0; bus0.key_valid = 1'b1;
        tick();
        bus0.key_valid = 1'b0; bus0.subkey_ready = 1'b1;
        repeat (4) tick();
        check_eq("pre_rst_valid", bus0.subkey_valid, 1);
        bus0.subkey_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", bus0.subkey_valid, 0);
        check_eq("arst_ready", bus0.key_ready, 1);
        check_eq("arst_subkey", bus0.subkey, 0);
        check_eq("arst_round", bus0.round, 0);
        check_eq("arst_last", bus0.last, 0);
        #4 rst_n = 1'b1;
        tick();
        run_job(64'h133457799BBCDFF1, 1'b0, 100, -1);
        for (int i = 0; i < 16; i++) check_eq("post_rst", got[i], got_enc[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
